clint_timer: RTL

Machine-mode timer and software-interrupt responder on the core's data-memory port. It accepts the same chip-enable, write-enable, byte-select, address and data signals the MEM stage drives for loads and stores, and returns read data in the same cycle. It maintains a 64-bit `mtime` counter, a `mtimecmp` comparator and an optional `msip` bit. Its interrupt outputs feed the MTIP/MSIP bits of the CSR file's `mip` register.

---
 rtl/clint_timer_pkg.sv | 19 +
 rtl/clint_byte_merge.sv | 14 +
 rtl/clint_timer.sv | 113 +++++++++++
 3 files changed

// File: rtl/clint_timer_pkg.sv
// Register indices and helpers shared by the CLINT timer block.
// The optional msip register is enabled by defining CLINT_MSIP_EN at build time.
package clint_timer_pkg;

  localparam int CLINT_IDX_W = 3;

  localparam logic [CLINT_IDX_W-1:0] CLINT_MSIP        = 3'd0;
  localparam logic [CLINT_IDX_W-1:0] CLINT_MTIMECMP_LO = 3'd1;
  localparam logic [CLINT_IDX_W-1:0] CLINT_MTIMECMP_HI = 3'd2;
  localparam logic [CLINT_IDX_W-1:0] CLINT_MTIME_LO    = 3'd3;
  localparam logic [CLINT_IDX_W-1:0] CLINT_MTIME_HI    = 3'd4;
  localparam logic [CLINT_IDX_W-1:0] CLINT_PRESCALE    = 3'd5;

  // A programmed prescale of 0 behaves exactly like 1.
  function automatic logic [15:0] clint_eff_prescale(input logic [15:0] p);
    return (p == 16'd0) ? 16'd1 : p;
  endfunction

endpackage

// File: rtl/clint_byte_merge.sv
// clint_byte_merge: per-lane merge of a store word into the old register word.
// Latency: combinational. Backpressure: none.
module clint_byte_merge (
  input  logic [31:0] old_dat,
  input  logic [31:0] new_dat,
  input  logic [3:0]  sel,
  output logic [31:0] merged_dat
);

  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign merged_dat[8*k +: 8] = sel[k] ? new_dat[8*k +: 8] : old_dat[8*k +: 8];
  end

endmodule

// File: rtl/clint_timer.sv
// clint_timer: mtime/mtimecmp/prescale (+ msip when CLINT_MSIP_EN) window on the MEM-stage data port.
// Latency: reads combinational, writes visible after one edge, IRQs one cycle after their source.
// Backpressure: none; every access completes in the cycle it is presented.
module clint_timer
  import clint_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR        = 32'h0200_0000,
  parameter logic [15:0] PRESCALE_DEFAULT = 16'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        hit_o,
  output logic        timer_irq_o,
  output logic        soft_irq_o
);

  logic [63:0] mtime_q;
  logic [63:0] mtimecmp_q;
  logic [15:0] prescale_q;
  logic [15:0] pcnt_q;
  logic        msip_q;

  logic [CLINT_IDX_W-1:0] idx;
  logic                   wr_en;
  logic                   tick;
  logic [63:0]            mtime_inc;
  logic [31:0]            mtime_lo_nxt, mtime_hi_nxt;
  logic [15:0]            pcnt_nxt;
  logic [31:0]            cmp_lo_mrg, cmp_hi_mrg, time_lo_mrg, time_hi_mrg, pre_mrg;

  assign hit_o = ce_i && (addr_i[31:5] == BASE_ADDR[31:5]);
  assign idx   = addr_i[4:2];
  assign wr_en = hit_o && we_i;

  // Byte offset bits are ignored; sel_i alone picks lanes.
  logic unused_ok;
  assign unused_ok = ^{addr_i[1:0], pre_mrg[31:16]};

  clint_byte_merge u_merge_cmp_lo (.old_dat(mtimecmp_q[31:0]),  .new_dat(data_i), .sel(sel_i), .merged_dat(cmp_lo_mrg));
  clint_byte_merge u_merge_cmp_hi (.old_dat(mtimecmp_q[63:32]), .new_dat(data_i), .sel(sel_i), .merged_dat(cmp_hi_mrg));
  clint_byte_merge u_merge_time_lo (.old_dat(mtime_q[31:0]),    .new_dat(data_i), .sel(sel_i), .merged_dat(time_lo_mrg));
  clint_byte_merge u_merge_time_hi (.old_dat(mtime_q[63:32]),   .new_dat(data_i), .sel(sel_i), .merged_dat(time_hi_mrg));
  clint_byte_merge u_merge_pre (.old_dat({16'h0000, prescale_q}), .new_dat(data_i), .sel(sel_i), .merged_dat(pre_mrg));

  assign tick      = (pcnt_q == clint_eff_prescale(prescale_q) - 16'd1);
  assign mtime_inc = mtime_q + 64'd1;

  // A write to one half overrides only that half; the other half keeps the increment/carry.
  always_comb begin
    mtime_lo_nxt = tick ? mtime_inc[31:0]  : mtime_q[31:0];
    mtime_hi_nxt = tick ? mtime_inc[63:32] : mtime_q[63:32];
    pcnt_nxt     = tick ? 16'd0 : pcnt_q + 16'd1;
    if (wr_en && idx == CLINT_MTIME_LO) mtime_lo_nxt = time_lo_mrg;
    if (wr_en && idx == CLINT_MTIME_HI) mtime_hi_nxt = time_hi_mrg;
    if (wr_en && idx == CLINT_PRESCALE) pcnt_nxt = 16'd0;
  end

  always_comb begin
    data_o = 32'h0000_0000;
    if (hit_o && !we_i) begin
      case (idx)
        CLINT_MSIP:        data_o = {31'h0, msip_q};
        CLINT_MTIMECMP_LO: data_o = mtimecmp_q[31:0];
        CLINT_MTIMECMP_HI: data_o = mtimecmp_q[63:32];
        CLINT_MTIME_LO:    data_o = mtime_q[31:0];
        CLINT_MTIME_HI:    data_o = mtime_q[63:32];
        CLINT_PRESCALE:    data_o = {16'h0000, prescale_q};
        default:           data_o = 32'h0000_0000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime_q     <= 64'd0;
      mtimecmp_q  <= '1;
      prescale_q  <= PRESCALE_DEFAULT;
      pcnt_q      <= 16'd0;
      timer_irq_o <= 1'b0;
      soft_irq_o  <= 1'b0;
    end else begin
      mtime_q     <= {mtime_hi_nxt, mtime_lo_nxt};
      pcnt_q      <= pcnt_nxt;
      if (wr_en && idx == CLINT_MTIMECMP_LO) mtimecmp_q[31:0]  <= cmp_lo_mrg;
      if (wr_en && idx == CLINT_MTIMECMP_HI) mtimecmp_q[63:32] <= cmp_hi_mrg;
      if (wr_en && idx == CLINT_PRESCALE)    prescale_q        <= pre_mrg[15:0];
      timer_irq_o <= (mtime_q >= mtimecmp_q);
      soft_irq_o  <= msip_q;
    end
  end

`ifdef CLINT_MSIP_EN
  logic [31:0] msip_mrg;
  logic        unused_msip;
  assign unused_msip = ^msip_mrg[31:1];

  clint_byte_merge u_merge_msip (.old_dat({31'h0, msip_q}), .new_dat(data_i), .sel(sel_i), .merged_dat(msip_mrg));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) msip_q <= 1'b0;
    else if (wr_en && idx == CLINT_MSIP) msip_q <= msip_mrg[0];
  end
`else
  assign msip_q = 1'b0;
`endif

endmodule
